diff_sequencer: RTL and testbench

- Controller that runs the backward (derivative) pass through the `different` derivative unit, one layer at a time, from the last layer down to layer 0.
- Per layer it fetches weight/x/z from layer memory, registers them onto the unit's inputs and captures the unit's combinational diff outputs. It then streams the required results to the gradient consumer over a valid/ready handshake.
- Sits between the layer parameter memory, the `different` instance and the gradient/update logic.

---
 rtl/diff_pkg.sv | 22 ++
 rtl/diff_kind_picker.sv | 32 +++
 rtl/diff_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_diff_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/diff_pkg.sv
// Shared types for the backward-pass sequencer: result kinds and FSM states.
package diff_pkg;

  localparam int KIND_WIDTH = 2;

  typedef enum logic [KIND_WIDTH-1:0] {
    COST   = 2'd0,
    DENSE  = 2'd1,
    TO_ALL = 2'd2,
    START  = 2'd3
  } kind_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT_RD,
    SETTLE,
    EMIT,
    DONE
  } state_t;

endpackage

// File: rtl/diff_kind_picker.sv
// Walks the per-layer result order COST -> DENSE -> TO_ALL -> START, skipping
// COST except on the last layer and START except on layer 0.
module diff_kind_picker
  import diff_pkg::*;
(
  input  kind_t kind,
  input  logic  is_last,
  input  logic  is_first,
  output kind_t next_kind,
  output logic  last_of_layer
);

  always_comb begin
    next_kind     = COST;
    last_of_layer = 1'b0;
    unique case (kind)
      COST:   next_kind = DENSE;
      DENSE:  next_kind = TO_ALL;
      TO_ALL: begin
        next_kind     = START;
        last_of_layer = !is_first;
      end
      START:  last_of_layer = 1'b1;
      default: last_of_layer = 1'b1;
    endcase
  end

  // is_last only matters for picking the first kind, which the sequencer does itself
  logic unused_is_last;
  assign unused_is_last = is_last;

endmodule

// File: rtl/diff_sequencer.sv
// Runs the derivative unit layer by layer from the last layer down to 0 and
// streams the captured results to the gradient consumer over valid/ready.
module diff_sequencer
  import diff_pkg::*;
#(
  parameter int size            = 3,
  parameter int data_size       = 16,
  parameter int cost_type_size  = 8,
  parameter int dense_type_size = 4,
  parameter int layer_count     = 4,
  parameter int layer_addr_size = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [cost_type_size-1:0]     cfg_cost_type,
  input  logic [dense_type_size-1:0]    cfg_dense_type,
  input  logic [size*data_size-1:0]     predict_value_in,
  output logic                          rd_en,
  output logic [layer_addr_size-1:0]    rd_addr,
  input  logic                          rd_valid,
  input  logic [size*data_size-1:0]     rd_weight,
  input  logic [size*data_size-1:0]     rd_x,
  input  logic [size*data_size-1:0]     rd_z,
  output logic [size*data_size-1:0]     weight,
  output logic [size*data_size-1:0]     x,
  output logic [size*data_size-1:0]     z,
  output logic [size*data_size-1:0]     predict_value,
  output logic [cost_type_size-1:0]     cost_type,
  output logic [dense_type_size-1:0]    dense_type,
  input  logic [size*data_size-1:0]     diff_dense_in,
  input  logic [size*data_size-1:0]     diff_start_in,
  input  logic [size*data_size-1:0]     diff_to_all_in,
  input  logic [size*data_size-1:0]     diff_cost_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [layer_addr_size-1:0]    out_layer,
  output logic [KIND_WIDTH-1:0]         out_kind,
  output logic [size*data_size-1:0]     out_data,
  output logic                          busy,
  output logic                          done
);

  localparam int W = size * data_size;
  localparam logic [layer_addr_size-1:0] LAST_LAYER = layer_addr_size'(layer_count - 1);

  state_t                       state_q, state_d;
  kind_t                        kind_q, kind_d;
  logic [layer_addr_size-1:0]   layer_q, layer_d;
  logic [cost_type_size-1:0]    cost_type_q, cost_type_d;
  logic [dense_type_size-1:0]   dense_type_q, dense_type_d;
  logic [W-1:0]                 predict_q, predict_d;
  logic [W-1:0]                 weight_q, weight_d;
  logic [W-1:0]                 x_q, x_d;
  logic [W-1:0]                 z_q, z_d;
  logic [W-1:0]                 res_cost_q, res_cost_d;
  logic [W-1:0]                 res_dense_q, res_dense_d;
  logic [W-1:0]                 res_to_all_q, res_to_all_d;
  logic [W-1:0]                 res_start_q, res_start_d;

  logic  is_last, is_first, last_of_layer;
  kind_t next_kind;

  assign is_last  = (layer_q == LAST_LAYER);
  assign is_first = (layer_q == '0);

  diff_kind_picker u_kind_picker (
    .kind          (kind_q),
    .is_last       (is_last),
    .is_first      (is_first),
    .next_kind     (next_kind),
    .last_of_layer (last_of_layer)
  );

  always_comb begin
    state_d      = state_q;
    kind_d       = kind_q;
    layer_d      = layer_q;
    cost_type_d  = cost_type_q;
    dense_type_d = dense_type_q;
    predict_d    = predict_q;
    weight_d     = weight_q;
    x_d          = x_q;
    z_d          = z_q;
    res_cost_d   = res_cost_q;
    res_dense_d  = res_dense_q;
    res_to_all_d = res_to_all_q;
    res_start_d  = res_start_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cost_type_d  = cfg_cost_type;
          dense_type_d = cfg_dense_type;
          predict_d    = predict_value_in;
          layer_d      = LAST_LAYER;
          state_d      = FETCH;
        end
      end
      FETCH: state_d = WAIT_RD;
      WAIT_RD: begin
        if (rd_valid) begin
          weight_d = rd_weight;
          x_d      = rd_x;
          z_d      = rd_z;
          state_d  = SETTLE;
        end
      end
      // operands were registered last cycle, so the unit's outputs are settled now
      SETTLE: begin
        res_cost_d   = diff_cost_in;
        res_dense_d  = diff_dense_in;
        res_to_all_d = diff_to_all_in;
        res_start_d  = diff_start_in;
        kind_d       = is_last ? COST : DENSE;
        state_d      = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (!last_of_layer) begin
            kind_d = next_kind;
          end else if (is_first) begin
            state_d = DONE;
          end else begin
            layer_d = layer_q - 1'b1;
            state_d = FETCH;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      kind_q       <= COST;
      layer_q      <= '0;
      cost_type_q  <= '0;
      dense_type_q <= '0;
      predict_q    <= '0;
      weight_q     <= '0;
      x_q          <= '0;
      z_q          <= '0;
      res_cost_q   <= '0;
      res_dense_q  <= '0;
      res_to_all_q <= '0;
      res_start_q  <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      layer_q      <= layer_d;
      cost_type_q  <= cost_type_d;
      dense_type_q <= dense_type_d;
      predict_q    <= predict_d;
      weight_q     <= weight_d;
      x_q          <= x_d;
      z_q          <= z_d;
      res_cost_q   <= res_cost_d;
      res_dense_q  <= res_dense_d;
      res_to_all_q <= res_to_all_d;
      res_start_q  <= res_start_d;
    end
  end

  assign rd_en         = (state_q == FETCH);
  assign rd_addr       = rd_en ? layer_q : '0;
  assign weight        = weight_q;
  assign x             = x_q;
  assign z             = z_q;
  assign predict_value = predict_q;
  assign cost_type     = cost_type_q;
  assign dense_type    = dense_type_q;
  assign out_valid     = (state_q == EMIT);
  assign out_layer     = out_valid ? layer_q : '0;
  assign out_kind      = out_valid ? kind_q : COST;
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      unique case (kind_q)
        COST:    out_data = res_cost_q;
        DENSE:   out_data = res_dense_q;
        TO_ALL:  out_data = res_to_all_q;
        START:   out_data = res_start_q;
        default: out_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_diff_sequencer.sv
// Randomized self-checking bench: a 3-layer and a 1-layer sequencer against a
// queue-based model of the expected (layer, kind, data) result stream.
module tb_diff_sequencer;

  localparam int W  = 48;
  localparam int LC = 3;

  typedef struct {
    int           layer;
    int           kind;
    logic [W-1:0] data;
  } item_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         start, start_b;
  logic [7:0]   cfg_cost_type;
  logic [3:0]   cfg_dense_type;
  logic [W-1:0] predict_value_in;
  logic [W-1:0] rd_weight, rd_x, rd_z;

  logic         rd_en, rd_valid, out_valid, out_ready, busy, done;
  logic [1:0]   rd_addr, out_layer, out_kind;
  logic [W-1:0] weight, x, z, predict_value, out_data;
  logic [7:0]   cost_type;
  logic [3:0]   dense_type;
  logic [W-1:0] diff_dense_in, diff_start_in, diff_to_all_in, diff_cost_in;

  logic         rd_en_b, rd_valid_b, out_valid_b, out_ready_b, busy_b, done_b;
  logic [0:0]   rd_addr_b, out_layer_b;
  logic [1:0]   out_kind_b;
  logic [W-1:0] weight_b, x_b, z_b, predict_value_b, out_data_b;
  logic [7:0]   cost_type_b;
  logic [3:0]   dense_type_b;
  logic [W-1:0] diff_dense_b, diff_start_b, diff_to_all_b, diff_cost_b;

  // stand-in for the combinational derivative unit
  function automatic logic [W-1:0] unitModel(int k, logic [W-1:0] w, logic [W-1:0] xx,
                                             logic [W-1:0] zz, logic [W-1:0] p);
    case (k)
      0:       return w ^ zz;
      1:       return xx + zz;
      2:       return w - xx;
      default: return ~zz ^ p;
    endcase
  endfunction

  assign diff_cost_in   = unitModel(0, weight, x, z, predict_value);
  assign diff_dense_in  = unitModel(1, weight, x, z, predict_value);
  assign diff_to_all_in = unitModel(2, weight, x, z, predict_value);
  assign diff_start_in  = unitModel(3, weight, x, z, predict_value);
  assign diff_cost_b    = unitModel(0, weight_b, x_b, z_b, predict_value_b);
  assign diff_dense_b   = unitModel(1, weight_b, x_b, z_b, predict_value_b);
  assign diff_to_all_b  = unitModel(2, weight_b, x_b, z_b, predict_value_b);
  assign diff_start_b   = unitModel(3, weight_b, x_b, z_b, predict_value_b);

  diff_sequencer #(.size(3), .data_size(16), .cost_type_size(8), .dense_type_size(4),
                   .layer_count(LC), .layer_addr_size(2)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_cost_type(cfg_cost_type),
    .cfg_dense_type(cfg_dense_type), .predict_value_in(predict_value_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_weight(rd_weight),
    .rd_x(rd_x), .rd_z(rd_z), .weight(weight), .x(x), .z(z),
    .predict_value(predict_value), .cost_type(cost_type), .dense_type(dense_type),
    .diff_dense_in(diff_dense_in), .diff_start_in(diff_start_in),
    .diff_to_all_in(diff_to_all_in), .diff_cost_in(diff_cost_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_layer(out_layer),
    .out_kind(out_kind), .out_data(out_data), .busy(busy), .done(done)
  );

  diff_sequencer #(.size(3), .data_size(16), .cost_type_size(8), .dense_type_size(4),
                   .layer_count(1), .layer_addr_size(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .cfg_cost_type(cfg_cost_type),
    .cfg_dense_type(cfg_dense_type), .predict_value_in(predict_value_in),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_valid(rd_valid_b), .rd_weight(rd_weight),
    .rd_x(rd_x), .rd_z(rd_z), .weight(weight_b), .x(x_b), .z(z_b),
    .predict_value(predict_value_b), .cost_type(cost_type_b), .dense_type(dense_type_b),
    .diff_dense_in(diff_dense_b), .diff_start_in(diff_start_b),
    .diff_to_all_in(diff_to_all_b), .diff_cost_in(diff_cost_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_layer(out_layer_b),
    .out_kind(out_kind_b), .out_data(out_data_b), .busy(busy_b), .done(done_b)
  );

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mem_w [LC], mem_x [LC], mem_z [LC];
  item_t        exp_q [$];
  int           addr_q [$];
  logic [7:0]   exp_cost;
  logic [3:0]   exp_dense;
  logic [W-1:0] exp_pred;

  int rd_cnt, rd_pend, rd_lat, stall_left, done_cnt, cyc, start_cyc, done_cyc;
  bit spurious_arm, stall_arm, rand_ready, expect_b2b, prev_done;

  task automatic checkOutput(string tag, logic [63:0] actual, logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic logic [W-1:0] randVec();
    return W'({$urandom(), $urandom()});
  endfunction

  // expected stream straight from the kind-order rules
  function automatic int buildModel(int lc);
    int n = 0;
    exp_q.delete();
    addr_q.delete();
    for (int l = lc - 1; l >= 0; l--) begin
      addr_q.push_back(l);
      for (int k = 0; k < 4; k++) begin
        if ((k == 0 && l != lc - 1) || (k == 3 && l != 0)) continue;
        exp_q.push_back('{l, k, unitModel(k, mem_w[l], mem_x[l], mem_z[l], exp_pred)});
        n++;
      end
    end
    return n;
  endfunction

  // one clock of DUT A: check current outputs, then drive inputs for the next edge
  task automatic applyStimulus(bit do_start, logic [7:0] ct, logic [3:0] dt, logic [W-1:0] pv);
    item_t h;
    @(negedge clk);
    cyc++;
    if (prev_done) checkOutput("busy_after_done", busy, 0);
    prev_done = done;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      checkOutput("busy_in_done", busy, 1);
      checkOutput("queue_empty_at_done", exp_q.size(), 0);
    end
    if (expect_b2b) checkOutput("back_to_back_valid", out_valid, 1);
    expect_b2b = 1'b0;

    rd_valid = 1'b0;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        rd_valid  = 1'b1;
        rd_weight = mem_w[rd_pend];
        rd_x      = mem_x[rd_pend];
        rd_z      = mem_z[rd_pend];
      end
    end else if (spurious_arm && out_valid) begin
      rd_valid     = 1'b1;
      rd_weight    = randVec();
      rd_x         = randVec();
      rd_z         = randVec();
      spurious_arm = 1'b0;
    end
    if (rd_en) begin
      if (addr_q.size() == 0) checkOutput("rd_en_unexpected", 1, 0);
      else checkOutput("rd_addr", rd_addr, addr_q.pop_front());
      rd_pend = int'(rd_addr);
      rd_cnt  = rd_lat;
    end

    if (stall_arm && out_valid && out_layer == 2'd1 && out_kind == 2'd1) begin
      stall_left = 5;
      stall_arm  = 1'b0;
    end
    if (stall_left > 0) begin
      out_ready = 1'b0;
      stall_left--;
    end else begin
      out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    end

    if (out_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("out_valid_unexpected", 1, 0);
      end else begin
        h = exp_q[0];
        checkOutput("out_layer", out_layer, h.layer);
        checkOutput("out_kind", out_kind, h.kind);
        checkOutput("out_data", out_data, h.data);
        checkOutput("weight", weight, mem_w[h.layer]);
        checkOutput("x", x, mem_x[h.layer]);
        checkOutput("z", z, mem_z[h.layer]);
        checkOutput("cost_type", cost_type, exp_cost);
        checkOutput("dense_type", dense_type, exp_dense);
        checkOutput("predict_value", predict_value, exp_pred);
        if (out_ready) begin
          void'(exp_q.pop_front());
          expect_b2b = (exp_q.size() != 0) && (exp_q[0].layer == h.layer);
        end
      end
    end

    start            = do_start;
    cfg_cost_type    = ct;
    cfg_dense_type   = dt;
    predict_value_in = pv;
  endtask

  task automatic prepPass(int lat, bit rready, bit stall, bit spur, bit fixed_cost, output int n);
    for (int l = 0; l < LC; l++) begin
      mem_w[l] = randVec();
      mem_x[l] = randVec();
      mem_z[l] = randVec();
    end
    exp_cost     = fixed_cost ? 8'h11 : 8'($urandom());
    exp_dense    = 4'($urandom());
    exp_pred     = randVec();
    n            = buildModel(LC);
    rd_lat       = lat;
    rand_ready   = rready;
    stall_arm    = stall;
    spurious_arm = spur;
    done_cnt     = 0;
  endtask

  task automatic runPass(int lat, bit rready, bit stall, bit spur, bit midstart, bit chklat);
    int n;
    prepPass(lat, rready, stall, spur, midstart, n);
    applyStimulus(1'b1, exp_cost, exp_dense, exp_pred);
    start_cyc = cyc;
    for (int i = 0; i < 600 && done_cnt == 0; i++)
      applyStimulus(midstart && i == 6, 8'hAA, ~exp_dense, ~exp_pred);
    checkOutput("done_seen", done_cnt, 1);
    if (chklat) checkOutput("pass_latency", done_cyc - start_cyc + 1, LC * (2 + lat) + n + 2);
    repeat (3) applyStimulus(1'b0, 8'hAA, 4'h5, randVec());
    checkOutput("single_done", done_cnt, 1);
  endtask

  task automatic checkResetState();
    checkOutput("rst_rd_en", rd_en, 0);
    checkOutput("rst_rd_addr", rd_addr, 0);
    checkOutput("rst_weight", weight, 0);
    checkOutput("rst_x", x, 0);
    checkOutput("rst_z", z, 0);
    checkOutput("rst_predict", predict_value, 0);
    checkOutput("rst_cost_type", cost_type, 0);
    checkOutput("rst_dense_type", dense_type, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_layer", out_layer, 0);
    checkOutput("rst_out_kind", out_kind, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
  endtask

  task automatic runResetAbort();
    int n;
    bit found = 1'b0;
    prepPass(20, 1'b0, 1'b0, 1'b0, 1'b0, n);
    applyStimulus(1'b1, exp_cost, exp_dense, exp_pred);
    for (int i = 0; i < 200 && !found; i++) begin
      applyStimulus(1'b0, 8'h00, 4'h0, '0);
      found = (rd_cnt > 0 && rd_pend == 1);
    end
    checkOutput("reached_wait_rd_layer1", found, 1);
    applyStimulus(1'b0, 8'h00, 4'h0, '0);
    reset = 1'b1;
    rd_cnt = 0;
    exp_q.delete();
    addr_q.delete();
    applyStimulus(1'b0, 8'h00, 4'h0, '0);
    checkResetState();
    reset = 1'b0;
    expect_b2b = 1'b0;
    prev_done  = 1'b0;
    repeat (4) applyStimulus(1'b0, 8'h00, 4'h0, '0);
    checkOutput("no_done_after_abort", done_cnt, 0);
    runPass(2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic runSingleLayer();
    int  rd_cnt_b = 0;
    int  kidx = 0;
    int  dcnt = 0;
    bit  pend = 1'b0;
    logic [W-1:0] w0 = randVec(), x0 = randVec(), z0 = randVec(), p0 = randVec();
    @(negedge clk);
    predict_value_in = p0;
    cfg_cost_type    = 8'h3C;
    cfg_dense_type   = 4'h9;
    start_b          = 1'b1;
    out_ready_b      = 1'b1;
    for (int i = 0; i < 60 && dcnt == 0; i++) begin
      @(negedge clk);
      start_b    = 1'b0;
      rd_valid_b = 1'b0;
      if (pend) begin
        rd_valid_b = 1'b1;
        rd_weight  = w0;
        rd_x       = x0;
        rd_z       = z0;
        pend       = 1'b0;
      end
      if (rd_en_b) begin
        rd_cnt_b++;
        checkOutput("b_rd_addr", rd_addr_b, 0);
        pend = 1'b1;
      end
      if (out_valid_b) begin
        checkOutput("b_out_layer", out_layer_b, 0);
        checkOutput("b_out_kind", out_kind_b, kidx);
        checkOutput("b_out_data", out_data_b, unitModel(kidx, w0, x0, z0, p0));
        kidx++;
      end
      if (done_b) dcnt++;
    end
    checkOutput("b_rd_count", rd_cnt_b, 1);
    checkOutput("b_kind_count", kidx, 4);
    checkOutput("b_done", dcnt, 1);
    checkOutput("b_cost_type", cost_type_b, 8'h3C);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0; start_b = 1'b0;
    rd_valid = 1'b0; rd_valid_b = 1'b0;
    out_ready = 1'b1; out_ready_b = 1'b1;
    cfg_cost_type = '0; cfg_dense_type = '0; predict_value_in = '0;
    rd_weight = '0; rd_x = '0; rd_z = '0;
    rd_cnt = 0; rd_pend = 0; rd_lat = 1; stall_left = 0; done_cnt = 0; cyc = 0;
    start_cyc = 0; done_cyc = 0;
    spurious_arm = 0; stall_arm = 0; rand_ready = 0; expect_b2b = 0; prev_done = 0;
    repeat (3) @(negedge clk);
    checkResetState();
    checkOutput("rst_b_busy", busy_b, 0);
    checkOutput("rst_b_out_valid", out_valid_b, 0);
    reset = 1'b0;

    $display("[TB] basic pass, rd latency 1");
    runPass(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    $display("[TB] backpressure on layer 1 DENSE");
    runPass(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("[TB] rd latency 7 with spurious rd_valid");
    runPass(7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    $display("[TB] start while busy");
    runPass(1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    $display("[TB] randomized passes");
    for (int i = 0; i < 4; i++) runPass($urandom_range(1, 5), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("[TB] reset during WAIT_RD");
    runResetAbort();
    $display("[TB] single-layer instance");
    runSingleLayer();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
